ysyx_210544_wbu: RTL

Writeback/commit-preparation stage of the ysyx_210544 core. Accepts one retiring instruction per cycle from the memory stage over a valid/ready handshake and registers it. Drives the register-file write port, and produces the per-instruction commit record (pc, inst, rd write, valid, skip, interrupt number) that the difftest commit unit samples. Also computes the skip flag for non-reproducible accesses, counts retired instructions, and halts intake after a trap instruction.

---
 rtl/ysyx_210544_wbu_if.sv | 40 ++++
 rtl/ysyx_210544_wbu.sv | 86 ++++++++
 2 files changed

// File: rtl/ysyx_210544_wbu_if.sv
// Memory-stage to writeback bundle: retiring-instruction inputs, handshake,
// register-file write port and commit record outputs.
interface ysyx_210544_wbu_if;
  logic        i_valid;
  logic        o_ready;
  logic [63:0] i_pc;
  logic [31:0] i_inst;
  logic [4:0]  i_rd;
  logic        i_rd_wen;
  logic [63:0] i_rd_wdata;
  logic        i_mem_access;
  logic [63:0] i_mem_addr;
  logic        i_csr_access;
  logic [11:0] i_csr_addr;
  logic [31:0] i_intrNo;
  logic [4:0]  o_rd;
  logic        o_rd_wen;
  logic [63:0] o_rd_wdata;
  logic [63:0] o_pc;
  logic [31:0] o_inst;
  logic        o_cmtvalid;
  logic        o_skipcmt;
  logic [31:0] o_intrNo;
  logic [63:0] o_instret;
  logic        o_halted;

  modport slave (
    input  i_valid, i_pc, i_inst, i_rd, i_rd_wen, i_rd_wdata,
           i_mem_access, i_mem_addr, i_csr_access, i_csr_addr, i_intrNo,
    output o_ready, o_rd, o_rd_wen, o_rd_wdata, o_pc, o_inst,
           o_cmtvalid, o_skipcmt, o_intrNo, o_instret, o_halted
  );

  modport master (
    output i_valid, i_pc, i_inst, i_rd, i_rd_wen, i_rd_wdata,
           i_mem_access, i_mem_addr, i_csr_access, i_csr_addr, i_intrNo,
    input  o_ready, o_rd, o_rd_wen, o_rd_wdata, o_pc, o_inst,
           o_cmtvalid, o_skipcmt, o_intrNo, o_instret, o_halted
  );
endinterface

// File: rtl/ysyx_210544_wbu.sv
// Writeback stage: registers one retiring instruction per cycle, drives the
// register-file write port and the difftest commit record, halts after a trap.
module ysyx_210544_wbu (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_210544_wbu_if.slave      wb
);
  logic [63:0] pc_reg;
  logic [31:0] inst_reg;
  logic [4:0]  rd_reg;
  logic        rd_wen_reg;
  logic [63:0] rd_wdata_reg;
  logic        cmtvalid_reg;
  logic        skip_reg;
  logic [31:0] intr_reg;
  logic [63:0] instret_reg;
  logic        halted_reg;

  logic acc;
  logic skip;
  logic mmio_skip;
  logic csr_skip;
  logic putch;
  logic trap;
  logic unused_addr_bits;

  assign acc = wb.i_valid & ~halted_reg;

  // Only the high bits decide MMIO; the low address bits are irrelevant here.
  assign unused_addr_bits = ^wb.i_mem_addr[30:0];
  assign mmio_skip = wb.i_mem_access & (wb.i_mem_addr[63:31] == 33'd0);
  assign csr_skip  = wb.i_csr_access &
                     ((wb.i_csr_addr == 12'hB00) ||
                      (wb.i_csr_addr == 12'hC00) ||
                      (wb.i_csr_addr == 12'h344));
  assign putch     = (wb.i_inst[6:0] == 7'h7b);
  assign trap      = (wb.i_inst[6:0] == 7'h6b);
  assign skip      = mmio_skip | csr_skip | putch;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg       <= '0;
      inst_reg     <= '0;
      rd_reg       <= '0;
      rd_wen_reg   <= 1'b0;
      rd_wdata_reg <= '0;
      cmtvalid_reg <= 1'b0;
      skip_reg     <= 1'b0;
      intr_reg     <= '0;
      instret_reg  <= '0;
      halted_reg   <= 1'b0;
    end else begin
      if (acc) begin
        pc_reg       <= wb.i_pc;
        inst_reg     <= wb.i_inst;
        rd_reg       <= wb.i_rd;
        rd_wen_reg   <= wb.i_rd_wen & (wb.i_rd != 5'd0);
        rd_wdata_reg <= wb.i_rd_wdata;
        cmtvalid_reg <= 1'b1;
        skip_reg     <= skip;
        intr_reg     <= wb.i_intrNo;
      end else begin
        rd_wen_reg   <= 1'b0;
        cmtvalid_reg <= 1'b0;
        intr_reg     <= '0;
      end
      // An interrupted instruction did not retire, so it is not counted.
      if (acc && (wb.i_intrNo == 32'd0))
        instret_reg <= instret_reg + 64'd1;
      if (acc && trap)
        halted_reg <= 1'b1;
    end
  end

  assign wb.o_ready    = ~halted_reg;
  assign wb.o_pc       = pc_reg;
  assign wb.o_inst     = inst_reg;
  assign wb.o_rd       = rd_reg;
  assign wb.o_rd_wen   = rd_wen_reg;
  assign wb.o_rd_wdata = rd_wdata_reg;
  assign wb.o_cmtvalid = cmtvalid_reg;
  assign wb.o_skipcmt  = skip_reg;
  assign wb.o_intrNo   = intr_reg;
  assign wb.o_instret  = instret_reg;
  assign wb.o_halted   = halted_reg;
endmodule
